alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Downstream stage of the 16-bit ALU.
- Consumes each registered ALU result and its SVNZC flags, and updates the architectural status register under a per-instruction flag mask.
- Buffers register-file writes in a small in-order FIFO, drained through a valid/ready handshake.
- Decouples ALU issue from register-file write-port stalls.

Parameters:
- DEPTH, 2, writeback FIFO entries; power of two, minimum 2.
- RADDR_W, 4, register-file address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept; equals not-full.
- in_y  input  16  ALU result.
- in_flags  input  5  ALU flags {s,v,n,z,c}; bit 0 = C.
- in_flag_mask  input  5  which status bits this instruction updates.
- in_wb_en  input  1  result is written to the register file.
- in_rd  input  RADDR_W  destination register.
- rf_we  output  1  write request valid; equals not-empty.
- rf_waddr  output  RADDR_W  head-entry destination.
- rf_wdata  output  16  head-entry data.
- rf_ready  input  1  register file accepts write.
- sr_we  input  1  software status-register write.
- sr_wdata  input  5  status value for sr_we.
- status  output  5  architectural SVNZC status register.
- occupancy  output  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset (async, resetn low): status=0, FIFO empty, occupancy=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - in_ready reads 1 during reset.
  - Any handshake during reset is ignored.
- Accept occurs when in_valid && in_ready at a rising edge.
  - in_valid with in_ready=0 is not consumed; upstream must hold in_y, in_flags, in_flag_mask, in_wb_en and in_rd stable.
- Flag update: on accept, status <= (status & ~in_flag_mask) | (in_flags & in_flag_mask).
  - Visible one cycle after the accept edge.
  - The update happens regardless of in_wb_en.
- sr_we has priority over a same-cycle accept for status: status <= sr_wdata.
  - The accepted result is still enqueued if in_wb_en=1.
- Enqueue: on accept with in_wb_en=1, push {in_rd, in_y}.
  - Accept with in_wb_en=0 updates flags only; no FIFO push.
  - It still requires in_ready=1, so instruction order is preserved.
- Dequeue: rf_we=1 whenever the FIFO is non-empty.
  - rf_waddr and rf_wdata come from the head entry, driven from registers with no combinational path from the in_* inputs.
  - Pop occurs when rf_we && rf_ready.
- Latency: result accepted at edge N appears on rf_we/rf_wdata in the cycle after edge N, provided the FIFO was empty.
- Simultaneous push and pop:
  - Allowed when not full; occupancy unchanged, pointers both advance.
  - When full, in_ready=0, so there is no push and no bypass even if rf_ready=1.
  - in_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH and never underflows; rf_ready while empty is ignored.
- Reset mid-operation discards all FIFO contents and clears status immediately.

Optional Feature:
- Macro: ALU_WB_STICKY_OVF_EN.
- Defined: status V bit (bit 3) is sticky.
  - On accept with in_flag_mask[3]=1, V <= V | in_flags[3].
  - V clears only via sr_we or reset; other bits are unchanged.
- Undefined: V follows the normal masked-replace rule.

Decomposition:
- Shared constants package additions:
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3, FLAG_S=4.
  - status_t packed typedef {s,v,n,z,c}.
  - wb_entry_t struct {rd, data}.
- One sub-module, wb_fifo: parameterised synchronous FIFO with async active-low reset, push/pop/full/empty/count.
- alu_writeback instantiates wb_fifo and holds the status register logic.

Test Plan:
- Reset, then accept y=16'h0007, flags=5'b00000, mask=5'b11111, wb_en=1, rd=3, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h0007, status=0; following cycle rf_we=0.
- rf_ready=0; accept 16'h1111, 16'h2222 (wb_en=1) -> occupancy=2, in_ready=0, third in_valid not consumed; raise rf_ready -> writes 16'h1111 then 16'h2222 in order; in_ready=1 the cycle after first pop.
- status=5'b11111; accept flags=5'b00000, mask=5'b00011, wb_en=0 -> status=5'b11100, occupancy unchanged at 0.
- Same cycle sr_we=1, sr_wdata=5'b10101 and accept flags=5'b01010, mask=5'b11111 -> status=5'b10101.
- ALU_WB_STICKY_OVF_EN: accept flags V=1, then flags V=0, both mask=5'b11111 -> status[3]=1 after both; sr_we with sr_wdata=0 -> status[3]=0. Without the macro -> status[3]=0 after the second accept.
- Fill FIFO (2 entries), assert resetn=0 mid-cycle -> rf_we=0, occupancy=0, status=0 immediately, no write emitted after release.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared constants and types for the ALU writeback stage.
// Flag bit positions, status register layout and the writeback FIFO entry.
package alu_writeback_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FLAG_W     = 5;
  localparam int unsigned WB_RADDR_W = 4;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_S = 4;

  typedef struct packed {
    logic s;
    logic v;
    logic n;
    logic z;
    logic c;
  } status_t;

  typedef struct packed {
    logic [WB_RADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Masked replace: bits selected by mask take the new flag value.
  function automatic status_t merge_flags(status_t cur, logic [FLAG_W-1:0] flags,
                                          logic [FLAG_W-1:0] mask);
    return status_t'((cur & ~mask) | (flags & mask));
  endfunction

endpackage

// File: rtl/alu_writeback_wb_fifo.sv
// In-order synchronous FIFO for pending register-file writes.
// Head entry is read straight from storage registers; async active-low reset.
module wb_fifo
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  output entry_t                     rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guarded here so the FIFO cannot over/underflow even if a caller misbehaves.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: masked status-register update plus buffered register-file writes.
// Build macro ALU_WB_STICKY_OVF_EN makes the V status bit sticky until sr_we or reset.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RADDR_W = WB_RADDR_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_y,
  input  logic [FLAG_W-1:0]        in_flags,
  input  logic [FLAG_W-1:0]        in_flag_mask,
  input  logic                     in_wb_en,
  input  logic [RADDR_W-1:0]       in_rd,
  output logic                     rf_we,
  output logic [RADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_ready,
  input  logic                     sr_we,
  input  logic [FLAG_W-1:0]        sr_wdata,
  output logic [FLAG_W-1:0]        status,
  output logic [$clog2(DEPTH):0]   occupancy
);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
  } slot_t;

  status_t status_q, status_d;
  slot_t   push_slot, head_slot;
  logic    accept, push, pop, full, empty;

  assign in_ready = ~full;
  assign rf_we    = ~empty;
  assign accept   = in_valid & in_ready;
  // Flag-only instructions still take a handshake slot to keep ordering.
  assign push     = accept & in_wb_en;
  assign pop      = rf_we & rf_ready;

  assign push_slot = '{rd: in_rd, data: in_y};
  assign rf_waddr  = head_slot.rd;
  assign rf_wdata  = head_slot.data;
  assign status    = status_q;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (slot_t)
  ) u_wb_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push),
    .wdata_i (push_slot),
    .pop_i   (pop),
    .rdata_o (head_slot),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  always_comb begin
    status_d = status_q;
    if (sr_we) begin
      status_d = status_t'(sr_wdata);
    end else if (accept) begin
      status_d = merge_flags(status_q, in_flags, in_flag_mask);
`ifdef ALU_WB_STICKY_OVF_EN
      if (in_flag_mask[FLAG_V]) status_d.v = status_q.v | in_flags[FLAG_V];
`else
      status_d.v = status_d.v;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) status_q <= '0;
    else         status_q <= status_d;
  end

endmodule
